seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//   Time-multiplexes one hex-to-7-segment decoder across a 4-digit
//   common-anode display.
//   - Holds a 16-bit display value and 4 decimal-point bits.
//   - Per digit slot, drives the selected nibble to the decoder and enables
//     that digit's anode.
//   - Inserts dead time between digits (anti-ghosting), suppresses leading
//     zeros, and double-buffers loads so a frame never tears.
// PARAMETERS
//   REFRESH_DIV  100000  clocks per digit slot (dead time + drive); legal range > DEAD_CYCLES
//   DEAD_CYCLES  16      clocks at slot start with all anodes off; >= 1
// PORTS
//   clk         in   1   system clock; all logic on rising edge
//   reset       in   1   synchronous, active-high reset
//   value       in   16  display value; digit k = value[4k+3:4k], digit 0 rightmost
//   dp          in   4   decimal points, active-high, bit k = digit k
//   load        in   1   1-cycle strobe; captures value/dp
//   lz_en       in   1   1 = leading-zero suppression enabled (sampled live)
//   hex_out     out  4   nibble to the external hex-to-7seg decoder
//   an          out  4   digit anodes, active-low, bit k = digit k
//   dp_n        out  1   decimal point segment, active-low
//   frame_tick  out  1   1-cycle pulse on the first cycle of each digit-0 slot
// BEHAVIOUR
//   Reset:
//   - an=4'b1111, hex_out=0, dp_n=1, frame_tick=0.
//   - Digit index idx=0, slot counter cnt=0, state BLANK.
//   - Active value/dp=0, shadow value/dp=0, pending=0.
//   - Reset asserted mid-frame returns all of the above within 1 cycle.
//   Counter:
//   - cnt runs 0..REFRESH_DIV-1.
//   - At REFRESH_DIV-1: cnt->0, idx->idx+1 mod 4.
//   FSM (2 states, outputs decoded from registered cnt/idx, no extra latency):
//   - BLANK: cnt < DEAD_CYCLES. an=1111, dp_n=1, hex_out=active nibble[idx].
//   - DRIVE: cnt >= DEAD_CYCLES. an=~(1<<idx), or 1111 if digit suppressed.
//     dp_n=~active_dp[idx]; hex_out=active nibble[idx].
//   Load and buffering:
//   - load=1: shadow<=value/dp, pending<=1.
//   - Repeated loads before the frame boundary overwrite the shadow; the last
//     one wins.
//   - Frame boundary = cycle with idx=3 and cnt=REFRESH_DIV-1.
//     - If load=1: active<=value/dp.
//     - Else if pending: active<=shadow.
//     - pending<=0 in either case.
//   - Active value never changes at any other cycle.
//   frame_tick: 1 when idx=0 and cnt=0, including the first cycle after reset
//   release.
//   Leading-zero suppression (lz_en=1):
//   - Digit k in {3,2,1} is blanked (anode held high, dp_n=1) when active
//     nibbles k..3 are all zero.
//   - Digit 0 is never blanked. Value 0 shows a single "0".
//   - lz_en=0: all digits drive.
//   Arithmetic: cnt width = clog2(REFRESH_DIV); idx 2-bit, wraps 3->0.
// TESTING (REFRESH_DIV=8, DEAD_CYCLES=2; cycle 0 = first cycle after reset=0)
//   1. Reset, then load value=16'h1234, dp=4'b0000 during cycle 0, lz_en=0.
//      - Cycles 0-31 (first frame): still display 0000.
//      - Cycles 32-33: an=1111.
//      - Cycles 34-39: an=1110, hex_out=4.
//      - Cycles 42-47: an=1101, hex_out=3.
//      - frame_tick high at cycles 0 and 32.
//   2. Active value=16'h00A0, lz_en=1.
//      - Digits 3 and 2 never drive (an bits 3,2 stay 1).
//      - Digit 1 shows A; digit 0 shows 0.
//      - Value 0 with lz_en=1: only an=1110 ever asserts.
//   3. Load 16'hAAAA at cycle 40, then 16'hBBBB at cycle 50.
//      - Display unchanged until cycle 63.
//      - From cycle 64 on: hex_out=B in every drive slot; A never shown.
//   4. Load pulse exactly at boundary cycle 63 with value=16'hC0DE.
//      - Cycle 66: hex_out=E, an=1110.
//      - pending=0 afterwards.
//   5. dp=4'b0101 active.
//      - dp_n=0 only during drive cycles of digits 0 and 2.
//      - dp_n=1 during every blank cycle.
//   6. Assert reset at cycle 45 (digit 1 drive).
//      - Next cycle: an=1111, dp_n=1, active value 0.
//      - Scan restarts at digit 0, with frame_tick on the first cycle after
//        reset release.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between a display-data source and the 4-digit 7-segment scan controller.
// The master supplies the value to show; the slave drives the decoder and anodes.
interface seg7_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_en;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_tick;

  modport master (
    output value, dp, load, lz_en,
    input  hex_out, an, dp_n, frame_tick
  );

  modport slave (
    input  value, dp, load, lz_en,
    output hex_out, an, dp_n, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with dead time,
// leading-zero suppression and frame-aligned double buffering of the display value.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_val_q, act_val_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [15:0]      sh_val_q, sh_val_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             pending_q, pending_d;

  logic             slot_end;
  logic             frame_end;
  logic [15:0]      act_shifted;
  logic [3:0]       supp_mask;
  logic             drive_en;

  // Slot counter, digit index, phase state and the shadow/active buffers.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    state_d   = state_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);

    cnt_d   = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    state_d = (cnt_d < CNT_DEAD) ? BLANK : DRIVE;

    if (bus.load) begin
      sh_val_d  = bus.value;
      sh_dp_d   = bus.dp;
      pending_d = 1'b1;
    end

    // A load coinciding with the frame boundary bypasses the shadow entirely.
    if (frame_end) begin
      if (bus.load) begin
        act_val_d = bus.value;
        act_dp_d  = bus.dp;
      end else if (pending_q) begin
        act_val_d = sh_val_q;
        act_dp_d  = sh_dp_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      act_val_q <= 16'h0000;
      act_dp_q  <= 4'h0;
      sh_val_q  <= 16'h0000;
      sh_dp_q   <= 4'h0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
    end
  end

  // Output decode straight from registered state so drive timing has no added latency.
  always_comb begin
    act_shifted  = act_val_q >> {idx_q, 2'b00};
    supp_mask[0] = 1'b0;
    supp_mask[1] = bus.lz_en && (act_val_q[15:4]  == 12'h000);
    supp_mask[2] = bus.lz_en && (act_val_q[15:8]  == 8'h00);
    supp_mask[3] = bus.lz_en && (act_val_q[15:12] == 4'h0);
    drive_en     = (state_q == DRIVE) && !supp_mask[idx_q];

    bus.hex_out    = act_shifted[3:0];
    bus.an         = drive_en ? ~(4'b0001 << idx_q) : 4'b1111;
    bus.dp_n       = drive_en ? ~act_dp_q[idx_q] : 1'b1;
    bus.frame_tick = !reset && (idx_q == 2'd0) && (cnt_q == '0);
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scan/buffer/reset scenarios
// plus a randomized run, all compared against a time-based behavioural model.
module tb_seg7_scan_ctrl;

  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  logic reset;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time since reset release plus the display buffers.
  int          t;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_adp, m_shdp;
  bit          m_pend;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      t = 0; m_act = '0; m_adp = '0; m_sh = '0; m_shdp = '0; m_pend = 0;
    end else begin
      if (t % FRAME == FRAME - 1) begin
        if (bus.load) begin
          m_act = bus.value; m_adp = bus.dp;
        end else if (m_pend) begin
          m_act = m_sh; m_adp = m_shdp;
        end
        m_pend = 0;
      end else if (bus.load) begin
        m_sh = bus.value; m_shdp = bus.dp; m_pend = 1;
      end
      t++;
    end
  endtask

  task automatic check_outputs();
    int          idx, cnt;
    logic [15:0] upper;
    logic [3:0]  one, e_an;
    bit          sup, drv, e_dpn, e_ft;
    idx   = (t / RD) % 4;
    cnt   = t % RD;
    upper = m_act >> (4 * idx);
    sup   = bus.lz_en && (idx != 0) && (upper == 16'h0);
    drv   = (cnt >= DC) && !sup;
    one   = 4'b0001;
    e_an  = drv ? ~(one << idx) : 4'b1111;
    e_dpn = drv ? ~m_adp[idx] : 1'b1;
    e_ft  = (t % FRAME == 0) && !reset;
    check("an", 16'(bus.an), 16'(e_an));
    check("hex_out", 16'(bus.hex_out), 16'(upper[3:0]));
    check("dp_n", 16'(bus.dp_n), 16'(e_dpn));
    check("frame_tick", 16'(bus.frame_tick), 16'(e_ft));
  endtask

  // One clock: model follows the edge, new inputs are applied, outputs are compared.
  task automatic cyc(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d, input bit lz);
    @(posedge clk);
    model_edge();
    #1;
    reset = r; bus.load = ld; bus.value = v; bus.dp = d; bus.lz_en = lz;
    #1;
    check_outputs();
  endtask

  function automatic logic [15:0] rand_value();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(0, 255));
      2:       return 16'($urandom_range(0, 4095));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int          rst_left;
    bit          lz;
    logic [15:0] v;

    t = 0; m_act = '0; m_adp = '0; m_sh = '0; m_shdp = '0; m_pend = 0;
    reset = 1'b1; bus.load = 0; bus.value = '0; bus.dp = '0; bus.lz_en = 0;

    // Deferred swap: loads within a frame land at the next boundary, last one wins.
    cyc(1, 0, 16'h0, 4'h0, 0);
    for (int c = 0; c < 96; c++) begin
      if (c == 0)       cyc(0, 1, 16'h1234, 4'h0, 0);
      else if (c == 40) cyc(0, 1, 16'hAAAA, 4'h0, 0);
      else if (c == 50) cyc(0, 1, 16'hBBBB, 4'h0, 0);
      else              cyc(0, 0, 16'h0, 4'h0, 0);
      case (c)
        0:  check("tick_c0", 16'(bus.frame_tick), 16'd1);
        20: begin check("old_an_c20", 16'(bus.an), 16'hB); check("old_hex_c20", 16'(bus.hex_out), 16'h0); end
        32: check("tick_c32", 16'(bus.frame_tick), 16'd1);
        33: check("dead_an_c33", 16'(bus.an), 16'hF);
        36: begin check("an_c36", 16'(bus.an), 16'hE); check("hex_c36", 16'(bus.hex_out), 16'h4); end
        44: begin check("an_c44", 16'(bus.an), 16'hD); check("hex_c44", 16'(bus.hex_out), 16'h3); end
        60: check("hex_c60", 16'(bus.hex_out), 16'h1);
        70: begin check("an_c70", 16'(bus.an), 16'hE); check("hex_c70", 16'(bus.hex_out), 16'hB); end
        default: ;
      endcase
    end

    // Load on the exact boundary cycle goes straight to the active value.
    cyc(1, 0, 16'h0, 4'h0, 0);
    for (int c = 0; c < 104; c++) begin
      if (c == 0)       cyc(0, 1, 16'h1234, 4'h0, 0);
      else if (c == 63) cyc(0, 1, 16'hC0DE, 4'h0, 0);
      else              cyc(0, 0, 16'h0, 4'h0, 0);
      case (c)
        66:  begin check("bnd_hex_c66", 16'(bus.hex_out), 16'hE); check("bnd_an_c66", 16'(bus.an), 16'hE); end
        84:  begin check("bnd_hex_c84", 16'(bus.hex_out), 16'h0); check("bnd_an_c84", 16'(bus.an), 16'hB); end
        100: check("bnd_hex_c100", 16'(bus.hex_out), 16'hE);
        default: ;
      endcase
    end

    // Leading-zero suppression and decimal points.
    cyc(1, 0, 16'h0, 4'h0, 1);
    for (int c = 0; c < 72; c++) begin
      if (c == 0) cyc(0, 1, 16'h00A0, 4'b0101, 1);
      else        cyc(0, 0, 16'h0, 4'h0, 1);
      case (c)
        36: begin check("lz_an_c36", 16'(bus.an), 16'hE); check("lz_hex_c36", 16'(bus.hex_out), 16'h0);
                  check("lz_dp_c36", 16'(bus.dp_n), 16'd0); end
        40: begin check("lz_an_c40", 16'(bus.an), 16'hF); check("lz_dp_c40", 16'(bus.dp_n), 16'd1); end
        44: begin check("lz_an_c44", 16'(bus.an), 16'hD); check("lz_hex_c44", 16'(bus.hex_out), 16'hA);
                  check("lz_dp_c44", 16'(bus.dp_n), 16'd1); end
        52: begin check("lz_an_c52", 16'(bus.an), 16'hF); check("lz_dp_c52", 16'(bus.dp_n), 16'd1); end
        60: check("lz_an_c60", 16'(bus.an), 16'hF);
        default: ;
      endcase
    end

    // Reset asserted mid-frame during digit 1 drive.
    cyc(1, 0, 16'h0, 4'h0, 0);
    for (int c = 0; c < 45; c++) begin
      if (c == 0) cyc(0, 1, 16'h1234, 4'b1111, 0);
      else        cyc(0, 0, 16'h0, 4'h0, 0);
    end
    cyc(1, 0, 16'h0, 4'h0, 0);
    cyc(0, 0, 16'h0, 4'h0, 0);
    check("rst_an", 16'(bus.an), 16'hF);
    check("rst_dp", 16'(bus.dp_n), 16'd1);
    check("rst_hex", 16'(bus.hex_out), 16'h0);
    check("rst_tick", 16'(bus.frame_tick), 16'd1);
    for (int c = 0; c < 40; c++) cyc(0, 0, 16'h0, 4'h0, 0);
    check("rst_cleared_hex", 16'(bus.hex_out), 16'h0);

    // Randomized traffic, including boundary loads, lz toggles and resets.
    rst_left = 0;
    lz = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 3);
      v = rand_value();
      if (rst_left > 0) begin
        rst_left--;
        cyc(1, $urandom_range(0, 1) == 0, v, 4'($urandom), lz);
      end else begin
        cyc(0, ($urandom_range(0, 11) == 0) || (t % FRAME == FRAME - 1 && $urandom_range(0, 3) == 0),
            v, 4'($urandom), lz);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
